// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the fetch stage and its instruction-buffer interface.
package fetch_stage_pkg;

  localparam int XLEN        = 32;
  localparam int FETCH_BYTES = 8;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] pc;
  } IF_IB_PACKET;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and memory.
interface fetch_stage_if #(
  parameter int XLEN = 32
);

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [63:0]     imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO with wrap-bit pointers, synchronous clear and an occupancy count.
module fetch_queue #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    wr_ptr;
  logic [CW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + CW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + CW'(1);
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clock) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset_n && !clear) assert (!(push && full));
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: issues aligned double-word requests, tracks in-order responses and
// forms instruction pairs for the instruction buffer, with squash/redirect support.
module fetch_stage #(
  parameter int              XLEN            = fetch_stage_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int              MAX_OUTSTANDING = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          squash,
  input  logic [XLEN-1:0]               redirect_pc,
  input  logic                          ib_ready,
  fetch_stage_if.master                 imem,
  output fetch_stage_pkg::IF_IB_PACKET  if_ib_packet [0:1]
);

  import fetch_stage_pkg::*;

  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam int CW = AW + 1;
  localparam int RW = XLEN + 64;

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   in_flight;
  logic [CW-1:0]   drop_cnt;
  logic [CW:0]     credit_used;

  logic            req_ok;
  logic            issue;
  logic            resp;
  logic            dropping;
  logic            accept_resp;
  logic            out_load;

  logic [XLEN-1:0] pcq_head;
  logic            pcq_empty;
  logic            pcq_full;
  logic [CW-1:0]   pcq_count;

  logic [RW-1:0]   rsp_head;
  logic            rsp_empty;
  logic            rsp_full;
  logic [CW-1:0]   rsp_count;

  logic [XLEN-1:0] head_pc;
  logic [63:0]     head_data;
  logic [XLEN-1:0] head_base;
  IF_IB_PACKET     slot0_nxt;
  IF_IB_PACKET     slot1_nxt;

  // Credit covers both requests in flight and responses parked in the FIFO,
  // so the response FIFO can never be pushed while full.
  assign credit_used = {1'b0, in_flight} + {1'b0, rsp_count};
  assign req_ok      = reset_n && !squash && (credit_used < (CW+1)'(MAX_OUTSTANDING));
  assign issue       = req_ok && imem.imem_req_ready;
  assign resp        = imem.imem_resp_valid;
  assign dropping    = (drop_cnt != '0);
  assign accept_resp = resp && !dropping && !squash;
  assign out_load    = !rsp_empty && ib_ready && !squash;

  assign imem.imem_req_valid = req_ok;
  assign imem.imem_req_addr  = pc & ~XLEN'(FETCH_BYTES - 1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= RESET_PC;
      in_flight <= '0;
      drop_cnt  <= '0;
    end else begin
      in_flight <= in_flight + CW'(issue) - CW'(resp);
      if (squash) begin
        pc       <= redirect_pc & ~XLEN'(3);
        drop_cnt <= in_flight - CW'(resp);
      end else begin
        if (issue)            pc       <= imem.imem_req_addr + XLEN'(FETCH_BYTES);
        if (resp && dropping) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  fetch_queue #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_queue (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (squash),
    .push      (issue),
    .push_data (pc),
    .pop       (accept_resp),
    .head      (pcq_head),
    .empty     (pcq_empty),
    .full      (pcq_full),
    .count     (pcq_count)
  );

  fetch_queue #(
    .WIDTH (RW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_rsp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (squash),
    .push      (accept_resp),
    .push_data ({pcq_head, imem.imem_resp_data}),
    .pop       (out_load),
    .head      (rsp_head),
    .empty     (rsp_empty),
    .full      (rsp_full),
    .count     (rsp_count)
  );

  // The PC keeps bit 2 of a misaligned redirect target so the first pair
  // can start at the upper word.
  always_comb begin
    slot0_nxt = '0;
    slot1_nxt = '0;
    head_pc   = rsp_head[RW-1:64];
    head_data = rsp_head[63:0];
    head_base = head_pc & ~XLEN'(FETCH_BYTES - 1);
    if (head_pc[2]) begin
      slot0_nxt.valid = 1'b1;
      slot0_nxt.inst  = head_data[63:32];
      slot0_nxt.pc    = head_base + XLEN'(4);
      slot0_nxt.npc   = head_base + XLEN'(8);
    end else begin
      slot0_nxt.valid = 1'b1;
      slot0_nxt.inst  = head_data[31:0];
      slot0_nxt.pc    = head_base;
      slot0_nxt.npc   = head_base + XLEN'(4);
      slot1_nxt.valid = 1'b1;
      slot1_nxt.inst  = head_data[63:32];
      slot1_nxt.pc    = head_base + XLEN'(4);
      slot1_nxt.npc   = head_base + XLEN'(8);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      if_ib_packet[0] <= '0;
      if_ib_packet[1] <= '0;
    end else if (out_load) begin
      if_ib_packet[0] <= slot0_nxt;
      if_ib_packet[1] <= slot1_nxt;
    end else begin
      if_ib_packet[0].valid <= 1'b0;
      if_ib_packet[1].valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n) begin
      assert (!(accept_resp && pcq_empty));
      assert (!(accept_resp && rsp_full));
      assert (!(issue && pcq_full));
      assert (pcq_count == in_flight - drop_cnt);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order memory model and a packet scoreboard.
module tb_fetch_stage;

  import fetch_stage_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] fpc;
    int          epoch;
  } req_t;

  typedef struct {
    IF_IB_PACKET s0;
    IF_IB_PACKET s1;
  } pair_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        squash = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ib_ready = 1'b1;
  IF_IB_PACKET pkt [0:1];

  fetch_stage_if #(.XLEN(32)) imem ();

  fetch_stage #(
    .XLEN            (32),
    .RESET_PC        (32'h0),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .squash       (squash),
    .redirect_pc  (redirect_pc),
    .ib_ready     (ib_ready),
    .imem         (imem),
    .if_ib_packet (pkt)
  );

  always #5 clock = ~clock;

  req_t        pend [$];
  pair_t       exp_q [$];
  int          vectors = 0;
  int          miscompares = 0;
  int          epoch = 0;
  int          pkt_cnt = 0;
  int          drop_seen = 0;
  int          hs_cnt = 0;
  bit          resp_en = 1'b1;
  logic [31:0] tb_pc = '0;
  logic [31:0] last_hs_addr = '0;
  IF_IB_PACKET last_p0 = '0;
  IF_IB_PACKET last_p1 = '0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic pair_t expect_pair(input logic [31:0] fpc);
    pair_t       p;
    logic [31:0] base;
    base = {fpc[31:3], 3'b000};
    p.s0 = '0;
    p.s1 = '0;
    if (fpc[2]) begin
      p.s0 = '{valid: 1'b1, inst: word(base + 4), npc: base + 8, pc: base + 4};
    end else begin
      p.s0 = '{valid: 1'b1, inst: word(base), npc: base + 4, pc: base};
      p.s1 = '{valid: 1'b1, inst: word(base + 4), npc: base + 8, pc: base + 4};
    end
    return p;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive_resp();
    if (reset_n && resp_en && pend.size() > 0) begin
      imem.imem_resp_valid = 1'b1;
      imem.imem_resp_data  = {word(pend[0].addr + 4), word(pend[0].addr)};
    end else begin
      imem.imem_resp_valid = 1'b0;
      imem.imem_resp_data  = '0;
    end
  endtask

  // One clock: sample pre-edge handshakes at the falling edge, then update the
  // memory model and scoreboard just after the rising edge.
  task automatic tick();
    bit          hs, rv, sq, rn;
    logic [31:0] ha, rpc;
    req_t        m;
    pair_t       e;
    @(negedge clock);
    rn  = reset_n;
    hs  = imem.imem_req_valid && imem.imem_req_ready;
    ha  = imem.imem_req_addr;
    rv  = imem.imem_resp_valid;
    sq  = squash;
    rpc = redirect_pc;
    if (sq || !rn) chk("req_valid_blocked", 128'(imem.imem_req_valid), 128'(0));
    @(posedge clock);
    #1;
    if (!rn) begin
      drive_resp();
      return;
    end
    if (rv && pend.size() > 0) begin
      m = pend.pop_front();
      if (sq || m.epoch != epoch) drop_seen++;
      else exp_q.push_back(expect_pair(m.fpc));
    end
    if (sq) begin
      epoch++;
      exp_q.delete();
      tb_pc = {rpc[31:2], 2'b00};
    end
    if (hs) begin
      chk("req_addr", 128'(ha), 128'({tb_pc[31:3], 3'b000}));
      hs_cnt++;
      last_hs_addr = ha;
      pend.push_back('{addr: ha, fpc: tb_pc, epoch: epoch});
      tb_pc = {tb_pc[31:3], 3'b000} + 32'd8;
    end
    drive_resp();
    if (pkt[0].valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pkt", 128'(pkt[0].valid), 128'(0));
      end else begin
        e = exp_q.pop_front();
        chk("slot0", 128'(pkt[0]), 128'(e.s0));
        chk("slot1", 128'(pkt[1]), 128'(e.s1));
      end
      last_p0 = pkt[0];
      last_p1 = pkt[1];
      pkt_cnt++;
    end else begin
      chk("slot1_idle", 128'(pkt[1].valid), 128'(0));
    end
  endtask

  task automatic wait_pkt(input string tag);
    int n;
    n = pkt_cnt;
    for (int i = 0; i < 30 && pkt_cnt == n; i++) tick();
    chk({tag, "_timeout"}, 128'(pkt_cnt != n), 128'(1));
  endtask

  initial begin
    int          n;
    int          d0;
    IF_IB_PACKET want;

    imem.imem_req_ready  = 1'b1;
    imem.imem_resp_valid = 1'b0;
    imem.imem_resp_data  = '0;

    // Reset state
    #1 reset_n = 1'b0;
    #2;
    chk("rst_req_valid", 128'(imem.imem_req_valid), 128'(0));
    chk("rst_slot0", 128'(pkt[0]), 128'(0));
    chk("rst_slot1", 128'(pkt[1]), 128'(0));
    tick();
    tick();
    reset_n = 1'b1;

    // Straight-line fetch from RESET_PC
    wait_pkt("first_pkt");
    chk("first_s0_pc", 128'(last_p0.pc), 128'(32'h0));
    chk("first_s0_npc", 128'(last_p0.npc), 128'(32'h4));
    chk("first_s1_pc", 128'(last_p1.pc), 128'(32'h4));
    chk("first_s1_npc", 128'(last_p1.npc), 128'(32'h8));
    chk("first_s1_valid", 128'(last_p1.valid), 128'(1));
    for (int i = 0; i < 6; i++) tick();

    // Backpressure fills the response FIFO to the credit limit
    ib_ready = 1'b0;
    n = hs_cnt;
    for (int i = 0; i < 10; i++) tick();
    chk("bp_req_valid", 128'(imem.imem_req_valid), 128'(0));
    chk("bp_fifo_count", 128'(dut.u_rsp_fifo.count), 128'(4));
    chk("bp_issued_le4", 128'((hs_cnt - n) <= 4), 128'(1));
    ib_ready = 1'b1;
    n = pkt_cnt;
    for (int i = 0; i < 4; i++) tick();
    chk("bp_burst_pkts", 128'(pkt_cnt - n), 128'(4));

    // Memory stall holds the request steady
    imem.imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 128'(imem.imem_req_valid), 128'(1));
      chk("stall_addr", 128'(imem.imem_req_addr), 128'({tb_pc[31:3], 3'b000}));
      chk("stall_inflight", 128'(dut.in_flight), 128'(0));
      chk("stall_pc", 128'(dut.pc), 128'(tb_pc));
    end
    imem.imem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Misaligned redirect
    squash = 1'b1;
    redirect_pc = 32'h0000_0106;
    tick();
    squash = 1'b0;
    redirect_pc = '0;
    chk("mis_pc", 128'(dut.pc), 128'(32'h104));
    chk("mis_addr", 128'(imem.imem_req_addr), 128'(32'h100));
    tick();
    chk("mis_hs0", 128'(last_hs_addr), 128'(32'h100));
    tick();
    chk("mis_hs1", 128'(last_hs_addr), 128'(32'h108));
    wait_pkt("mis_pkt");
    want = '{valid: 1'b1, inst: word(32'h104), npc: 32'h108, pc: 32'h104};
    chk("mis_s0", 128'(last_p0), 128'(want));
    chk("mis_s1_valid", 128'(last_p1.valid), 128'(0));

    // Squash with three in flight and a response in the squash cycle
    imem.imem_req_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    resp_en = 1'b0;
    imem.imem_req_ready = 1'b1;
    n = hs_cnt;
    for (int i = 0; i < 3; i++) tick();
    chk("sq3_issued", 128'(hs_cnt - n), 128'(3));
    imem.imem_req_ready = 1'b0;
    resp_en = 1'b1;
    drive_resp();
    squash = 1'b1;
    redirect_pc = 32'h0000_0200;
    d0 = drop_seen;
    tick();
    squash = 1'b0;
    redirect_pc = '0;
    chk("sq3_drop_cnt", 128'(dut.drop_cnt), 128'(2));
    chk("sq3_in_flight", 128'(dut.in_flight), 128'(2));
    imem.imem_req_ready = 1'b1;
    wait_pkt("sq3_pkt");
    chk("sq3_first_pc", 128'(last_p0.pc), 128'(32'h200));
    chk("sq3_drops", 128'(drop_seen - d0), 128'(3));

    // Asynchronous reset between edges
    for (int i = 0; i < 3; i++) tick();
    wait_pkt("ar_pkt");
    #2 reset_n = 1'b0;
    #1;
    chk("ar_slot0", 128'(pkt[0]), 128'(0));
    chk("ar_slot1", 128'(pkt[1]), 128'(0));
    chk("ar_req_valid", 128'(imem.imem_req_valid), 128'(0));
    chk("ar_in_flight", 128'(dut.in_flight), 128'(0));
    chk("ar_fifo_count", 128'(dut.u_rsp_fifo.count), 128'(0));
    pend.delete();
    exp_q.delete();
    epoch++;
    tb_pc = '0;
    drive_resp();
    tick();
    tick();
    reset_n = 1'b1;
    wait_pkt("ar_restart");
    chk("ar_restart_pc", 128'(last_p0.pc), 128'(32'h0));
    chk("ar_restart_s1_pc", 128'(last_p1.pc), 128'(32'h4));

    for (int i = 0; i < 5; i++) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch stage directly upstream of the instruction buffer. It issues 64-bit aligned instruction-memory requests and tracks up to MAX_OUTSTANDING in-order responses.
- Each returned double-word becomes an if_ib_packet[0:1] pair. Slot 0 is always the first valid instruction, because the instruction buffer writes only on slot 0 valid.
- Handles squash/redirect by discarding in-flight responses, and honours ib_ready backpressure through an internal response FIFO.

Parameters:
- RESET_PC, 0, PC loaded on reset.
- MAX_OUTSTANDING, 4, maximum of (requests in flight + buffered responses). Must be a power of 2 and at least 2.
- XLEN, 32, PC/instruction width.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- squash  in  1  flush and redirect; same meaning as the squash input of the instruction buffer.
- redirect_pc  in  XLEN  new fetch PC, sampled when squash=1.
- ib_ready  in  1  downstream buffer can accept one packet pair this cycle.
- imem_req_valid  out  1  request valid.
- imem_req_addr  out  XLEN  request address, always 8-byte aligned.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_resp_valid  in  1  response valid; responses return in request order, at least 1 cycle after acceptance.
- imem_resp_data  in  64  [31:0] = word at addr, [63:32] = word at addr+4.
- if_ib_packet  out  IF_IB_PACKET[0:1]  fetched pair (valid, inst, PC, NPC per slot), registered.

Behaviour:
- Reset (async, reset_n=0):
  - pc=RESET_PC, in_flight=0, drop_cnt=0.
  - PC queue and response FIFO empty.
  - if_ib_packet fully zero.
  - imem_req_valid=0 while in reset.
- Issue:
  - imem_req_valid = !squash && (in_flight + fifo_count < MAX_OUTSTANDING). Combinational; must not depend on imem_req_ready.
  - imem_req_addr = {pc[XLEN-1:3], 3'b000}.
  - On handshake (valid & ready): push pc into the PC queue, in_flight++, pc <= imem_req_addr + 8.
- Response:
  - Each imem_resp_valid decrements in_flight.
  - If drop_cnt>0: discard the response, drop_cnt--, no PC-queue pop.
  - Otherwise: pop the PC queue and push {pc, data} into the response FIFO (depth MAX_OUTSTANDING).
  - The credit rule guarantees the FIFO never overflows. Overflow is an assertion failure.
  - Simultaneous issue and response in one cycle: in_flight unchanged.
- Packet formation, from the FIFO head with base = pc & ~7:
  - pc[2]=0: slot0 = {1, data[31:0], base, base+4}; slot1 = {1, data[63:32], base+4, base+8}.
  - pc[2]=1 (misaligned redirect target): slot0 = {1, data[63:32], base+4, base+8}; slot1 valid=0 (other slot1 fields zero).
- Output register, each cycle:
  - If FIFO non-empty && ib_ready && !squash: load the formed pair and pop the FIFO.
  - Otherwise: both slot valids=0 (data fields may hold).
  - Latency: response accepted at edge t → packet visible after edge t+1, given ib_ready.
- Squash (priority over everything except reset):
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - PC queue and FIFO cleared; output valids <= 0; no request issued that cycle.
  - drop_cnt <= in_flight - (imem_resp_valid ? 1 : 0). A response arriving in the squash cycle is itself discarded.
  - in_flight then counts down normally through the drops.
  - Squash while drop_cnt>0: same formula; in_flight already includes the outstanding drops.
  - Issue resumes next cycle if credit allows. New responses are only accepted after drop_cnt reaches 0, which is guaranteed by in-order return.
- Counter widths:
  - in_flight, drop_cnt, fifo_count: $clog2(MAX_OUTSTANDING)+1 bits.
  - Queue pointers: $clog2(MAX_OUTSTANDING)+1 bits with a wrap bit; full = MSB differs and low bits equal.
- Reset asserted mid-operation: everything returns to reset values immediately; responses arriving after reset deasserts are undefined memory behaviour, not handled.

Decomposition:
- Shared package: IF_IB_PACKET (valid, inst, NPC, PC), the XLEN constant, and a FETCH_BYTES=8 constant.
- One natural sub-module: fetch_queue, a parameterised synchronous FIFO (WIDTH, DEPTH, push/pop/clear, count). Instantiated twice: the PC queue (XLEN wide) and the response FIFO (XLEN+64 wide).

Test Plan:
- Reset: RESET_PC=0x0, req_ready=1, 1-cycle memory, ib_ready=1 → request addresses 0x0, 0x8, 0x10…; first packet slot0 PC=0x0 NPC=0x4, slot1 PC=0x4 NPC=0x8, both valid.
- Misaligned redirect: squash with redirect_pc=0x104 → next request addr 0x100; packet slot0 = data[63:32], PC=0x104, NPC=0x108, slot1.valid=0; following request addr 0x108.
- Squash with 3 in flight plus a response in the same cycle → drop_cnt=2; the next 2 responses are discarded; the first emitted packet PC equals the redirect target.
- Backpressure: ib_ready=0 for 10 cycles with MAX_OUTSTANDING=4 → at most 4 requests issued, FIFO count=4, req_valid=0; on ib_ready=1, 4 consecutive packets in order with no loss.
- Memory stall: imem_req_ready=0 for 5 cycles → req_valid and req_addr held stable, pc unchanged, in_flight unchanged.
- Async reset mid-burst: reset_n low between edges → outputs zero immediately, without waiting for a clock edge.
